mod_load_counter: RTL and testbench

- Counter that sits on the far end of the count_ifc bundle: the block that the test stimulus drives through P, Load, Enable and MR, and whose count it observes on Q.
- Synchronous loadable up/down modulo-N counter with a terminal-count output, a registered carry-out pulse and a sticky overflow flag.
- Used directly by the counter test bench and as a building block for cascaded timers.

---
 rtl/mod_load_counter_if.sv | 29 ++
 rtl/mod_load_counter.sv | 95 +++++++++
 tb/tb_mod_load_counter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_load_counter_if.sv
// Counter-side bundle: parallel load value and controls towards the counter,
// count, terminal count, carry pulse and overflow flag back from it.
interface mod_load_counter_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] P;
  logic             Load;
  logic             Enable;
  logic             Up;
  logic             OvfClr;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CO;
  logic             Ovf;

  // Stimulus side: drives the controls, observes the count
  modport master (
    output P, Load, Enable, Up, OvfClr,
    input  Q, TC, CO, Ovf
  );

  // Counter side
  modport slave (
    input  P, Load, Enable, Up, OvfClr,
    output Q, TC, CO, Ovf
  );

endinterface

// File: rtl/mod_load_counter.sv
// Loadable up/down modulo-MODULUS counter with combinational terminal count,
// registered one-cycle carry/borrow pulse and sticky overflow flag.
// Optional feature: define MOD_LOAD_COUNTER_SATURATE_EN to hold the count at
// the end of its range instead of wrapping (overflow flag still set, no CO).
module mod_load_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                  CLK,
  input  logic                  MR,
  mod_load_counter_if.slave     bus
);

  // Reject a modulus that cannot be represented or is meaningless
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "mod_load_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_COUNT
  } op_e;

  op_e              op;
  logic             at_end;
  logic [WIDTH-1:0] load_val;

  logic [WIDTH-1:0] q_q,   q_d;
  logic             co_q,  co_d;
  logic             ovf_q, ovf_d;

  // Decode operation priority (load over count over hold) and range end
  always_comb begin
    op = OP_HOLD;
    if (bus.Load) begin
      op = OP_LOAD;
    end else if (bus.Enable) begin
      op = OP_COUNT;
    end
    at_end   = bus.Up ? (q_q == Q_MAX) : (q_q == '0);
    load_val = (bus.P > Q_MAX) ? Q_MAX : bus.P;
  end

  // Next count, carry pulse and overflow flag; a wrap sets Ovf even when
  // OvfClr is asserted in the same cycle, so the set is applied last
  always_comb begin
    q_d   = q_q;
    co_d  = 1'b0;
    ovf_d = bus.OvfClr ? 1'b0 : ovf_q;
    case (op)
      OP_LOAD: begin
        q_d = load_val;
      end
      OP_COUNT: begin
        if (at_end) begin
          ovf_d = 1'b1;
`ifndef MOD_LOAD_COUNTER_SATURATE_EN
          q_d  = bus.Up ? '0 : Q_MAX;
          co_d = 1'b1;
`endif
        end else begin
          q_d = bus.Up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with asynchronous master reset
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      q_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.CO  = co_q;
  assign bus.Ovf = ovf_q;
  assign bus.TC  = (op == OP_COUNT) && at_end;

  // Control inputs must be known whenever the counter is out of reset
  a_ctrl_known: assert property (@(posedge CLK) disable iff (MR)
    !$isunknown({bus.Load, bus.Enable}));

endmodule

// File: tb/tb_mod_load_counter.sv
// Bench for mod_load_counter: a modulo-16 and a modulo-10 instance share the
// same stimulus; an arithmetic reference model tracks both and is compared
// every cycle, with literal expectations at the interesting points.
module tb_mod_load_counter;

`ifdef MOD_LOAD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic CLK;
  logic MR;

  mod_load_counter_if #(.WIDTH(4)) bus16 ();
  mod_load_counter_if #(.WIDTH(4)) bus10 ();

  mod_load_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CLK (CLK),
    .MR  (MR),
    .bus (bus16.slave)
  );

  mod_load_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .CLK (CLK),
    .MR  (MR),
    .bus (bus10.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int mq16 = 0, mco16 = 0, movf16 = 0;
  int mq10 = 0, mco10 = 0, movf10 = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: modular arithmetic on an integer count
  task automatic model_step(input int m, input int q, input int ovf,
                            input bit ld, input bit en, input bit up,
                            input bit clr, input int p,
                            output int nq, output int nco, output int novf);
    bit wrap;
    nq   = q;
    nco  = 0;
    novf = clr ? 0 : ovf;
    if (ld) begin
      nq = (p > m - 1) ? m - 1 : p;
    end else if (en) begin
      wrap = up ? (q == m - 1) : (q == 0);
      if (wrap) novf = 1;
      if (wrap && SAT) begin
        nq = q;
      end else begin
        nq  = (q + (up ? 1 : m - 1)) % m;
        nco = wrap ? 1 : 0;
      end
    end
  endtask

  function automatic int model_tc(input int m, input int q, input bit ld,
                                  input bit en, input bit up);
    return (en && !ld && (up ? q == m - 1 : q == 0)) ? 1 : 0;
  endfunction

  always @(posedge CLK or posedge MR) begin
    if (MR) begin
      mq16 = 0; mco16 = 0; movf16 = 0;
      mq10 = 0; mco10 = 0; movf10 = 0;
    end else begin
      model_step(16, mq16, movf16, bus16.Load, bus16.Enable, bus16.Up,
                 bus16.OvfClr, int'(bus16.P), mq16, mco16, movf16);
      model_step(10, mq10, movf10, bus10.Load, bus10.Enable, bus10.Up,
                 bus10.OvfClr, int'(bus10.P), mq10, mco10, movf10);
    end
  end

  // Per-cycle comparison, well after the edge
  always @(posedge CLK) begin
    #2;
    chk("q16",   int'(bus16.Q),   mq16);
    chk("co16",  int'(bus16.CO),  mco16);
    chk("ovf16", int'(bus16.Ovf), movf16);
    chk("tc16",  int'(bus16.TC),
        model_tc(16, mq16, bus16.Load, bus16.Enable, bus16.Up));
    chk("q10",   int'(bus10.Q),   mq10);
    chk("co10",  int'(bus10.CO),  mco10);
    chk("ovf10", int'(bus10.Ovf), movf10);
    chk("tc10",  int'(bus10.TC),
        model_tc(10, mq10, bus10.Load, bus10.Enable, bus10.Up));
  end

  task automatic set_in(input bit ld, input bit en, input bit up,
                        input bit clr, input logic [3:0] p);
    bus16.Load = ld; bus16.Enable = en; bus16.Up = up; bus16.OvfClr = clr; bus16.P = p;
    bus10.Load = ld; bus10.Enable = en; bus10.Up = up; bus10.OvfClr = clr; bus10.P = p;
  endtask

  task automatic drive(input bit ld, input bit en, input bit up,
                       input bit clr, input logic [3:0] p);
    set_in(ld, en, up, clr, p);
    @(negedge CLK);
  endtask

  initial begin
    MR = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    #1 MR = 1'b1;
    #2;
    chk("rst_q16",   int'(bus16.Q),   0);
    chk("rst_ovf16", int'(bus16.Ovf), 0);
    #9 MR = 1'b0;
    @(negedge CLK);
    chk("resume1_q16", int'(bus16.Q), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("resume2_q16", int'(bus16.Q), 2);

    // Wrap up from 0 on the modulo-16 counter
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("top_q16",  int'(bus16.Q),  15);
    chk("top_tc16", int'(bus16.TC), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("wrap_q16",   int'(bus16.Q),   SAT ? 15 : 0);
    chk("wrap_co16",  int'(bus16.CO),  SAT ? 0 : 1);
    chk("wrap_ovf16", int'(bus16.Ovf), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("co_pulse16", int'(bus16.CO), 0);

    // Load wins over Enable, then hold
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0111);
    chk("load_q16",  int'(bus16.Q),  7);
    chk("load_co16", int'(bus16.CO), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("hold_q16", int'(bus16.Q), 7);

    // Asynchronous reset mid-count, spanning a rising edge
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    #3 MR = 1'b1;
    #1;
    chk("async_q16",   int'(bus16.Q),   0);
    chk("async_co16",  int'(bus16.CO),  0);
    chk("async_ovf16", int'(bus16.Ovf), 0);
    #5 MR = 1'b0;
    @(negedge CLK);
    chk("post_rst_q16", int'(bus16.Q), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("post_rst1_q16", int'(bus16.Q), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("post_rst2_q16", int'(bus16.Q), 2);

    // Clamped load and down wrap on the modulo-10 counter
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd12);
    chk("clamp_q10", int'(bus10.Q), 9);
    chk("noclamp_q16", int'(bus16.Q), 12);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("bottom_q10",  int'(bus10.Q),  0);
    chk("bottom_tc10", int'(bus10.TC), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("dwrap_q10",   int'(bus10.Q),   SAT ? 0 : 9);
    chk("dwrap_co10",  int'(bus10.CO),  SAT ? 0 : 1);
    chk("dwrap_ovf10", int'(bus10.Ovf), 1);

    // Overflow clear racing a wrap, then clear alone
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    chk("race_ovf10", int'(bus10.Ovf), 1);
    chk("race_q10",   int'(bus10.Q),   SAT ? 9 : 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("clr_ovf10", int'(bus10.Ovf), 0);

    // Three up-counts from the top of the modulo-16 range
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("top3_q16",   int'(bus16.Q),   SAT ? 15 : 2);
    chk("top3_co16",  int'(bus16.CO),  0);
    chk("top3_ovf16", int'(bus16.Ovf), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(3) != 0), 1'($urandom),
            ($urandom_range(7) == 0), 4'($urandom));
    end

    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
